// File: rtl/pipe_scheduler_if.sv
// Bundle of game-control inputs and pipe-state outputs for pipe_scheduler.
// The master side drives Start/Lost/Tick/BirdX; the slave side drives pipe state.
interface pipe_scheduler_if;
    logic       Start;
    logic       Lost;
    logic       Tick;
    logic [9:0] BirdX;
    logic [9:0] PipeX0, PipeX1, PipeX2;
    logic [9:0] PipeY0, PipeY1, PipeY2;
    logic [2:0] PipeValid;
    logic       ScoreInc;
    logic       Running;
    logic       SpawnOverrun;

    modport master (
        output Start, Lost, Tick, BirdX,
        input  PipeX0, PipeX1, PipeX2, PipeY0, PipeY1, PipeY2,
        input  PipeValid, ScoreInc, Running, SpawnOverrun
    );

    modport slave (
        input  Start, Lost, Tick, BirdX,
        output PipeX0, PipeX1, PipeX2, PipeY0, PipeY1, PipeY2,
        output PipeValid, ScoreInc, Running, SpawnOverrun
    );
endinterface

// File: rtl/pipe_scheduler.sv
// Game-state FSM plus three pipe slots that scroll left one pixel per Tick and
// respawn at SPAWN_X every SPAWN_INTERVAL Ticks with an LFSR-derived gap height.
module pipe_scheduler #(
    parameter int unsigned SPAWN_X        = 800,
    parameter int unsigned SPAWN_INTERVAL = 267
) (
    input  logic            Clk,
    input  logic            Reset,
    pipe_scheduler_if.slave bus
);
    localparam logic [9:0] SPAWN_X_V = 10'(SPAWN_X);
    localparam logic [9:0] RELOAD    = 10'(SPAWN_INTERVAL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t     state, state_next;
    logic       do_tick, do_clear, do_start;
    logic [9:0] x_q [3];
    logic [9:0] y_q [3];
    logic [2:0] valid_q;
    logic [9:0] spawn_cnt;
    logic [8:0] lfsr;
    logic       score_q, overrun_q;
    logic [1:0] free_slot;
    logic       have_free, bird_hit;
    logic [8:0] lfsr_fold;
    logic [9:0] gap_y;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Lost outranks Tick and Start while running.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_next = state;
        do_tick    = 1'b0;
        do_clear   = 1'b0;
        do_start   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.Start && !bus.Lost) begin
                    state_next = RUN;
                    do_start   = 1'b1;
                end
            end
            RUN: begin
                if (bus.Lost)          state_next = FROZEN;
                else if (bus.Tick)     do_tick    = 1'b1;
            end
            FROZEN: begin
                if (bus.Start && !bus.Lost) begin
                    state_next = IDLE;
                    do_clear   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lowest free slot (as of before this Tick) and bird-crossing detect.
    always_comb begin
        free_slot = 2'd0;
        have_free = 1'b0;
        bird_hit  = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_slot = 2'(i);
                have_free = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (valid_q[i] && (x_q[i] == bus.BirdX)) bird_hit = 1'b1;
        end
    end

    assign lfsr_fold = (lfsr < 9'd475) ? lfsr : (lfsr - 9'd475);
    assign gap_y     = 10'(lfsr_fold) + 10'd25;

    // Taps at bits 9 and 5 of x^9+x^5+1; maximal length, period 511.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) lfsr <= 9'h001;
        else       lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 3; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            valid_q   <= '0;
            spawn_cnt <= '0;
            score_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            score_q <= 1'b0;
            if (do_clear) begin
                for (int i = 0; i < 3; i++) begin
                    x_q[i] <= '0;
                    y_q[i] <= '0;
                end
                valid_q   <= '0;
                overrun_q <= 1'b0;
            end else if (do_start) begin
                spawn_cnt <= '0;
            end else if (do_tick) begin
                score_q <= bird_hit;
                for (int i = 0; i < 3; i++) begin
                    if (valid_q[i]) begin
                        if (x_q[i] == 10'd0) valid_q[i] <= 1'b0;
                        else                 x_q[i]     <= x_q[i] - 10'd1;
                    end
                end
                // The spawn target was already invalid, so the scroll loop never touches it.
                if (spawn_cnt == 10'd0) begin
                    spawn_cnt <= RELOAD;
                    if (have_free) begin
                        x_q[free_slot]     <= SPAWN_X_V;
                        y_q[free_slot]     <= gap_y;
                        valid_q[free_slot] <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end else begin
                    spawn_cnt <= spawn_cnt - 10'd1;
                end
            end
        end
    end

    assign bus.PipeX0       = x_q[0];
    assign bus.PipeX1       = x_q[1];
    assign bus.PipeX2       = x_q[2];
    assign bus.PipeY0       = y_q[0];
    assign bus.PipeY1       = y_q[1];
    assign bus.PipeY2       = y_q[2];
    assign bus.PipeValid    = valid_q;
    assign bus.ScoreInc     = score_q;
    assign bus.Running      = (state == RUN);
    assign bus.SpawnOverrun = overrun_q;
endmodule

// File: tb/tb_pipe_scheduler.sv
// Self-checking bench: four pipe_scheduler instances with different parameters share
// one stimulus stream; table vectors, hand sequences and a gap-value scoreboard.
module tb_pipe_scheduler;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       start, lost, tick;
    logic [9:0] birdx;
    int         n_total = 0;
    int         n_pass  = 0;
    logic [8:0] m_lfsr;
    logic [9:0] exp_q [$];

    always #5 Clk = ~Clk;

    pipe_scheduler_if if_a ();
    pipe_scheduler_if if_b ();
    pipe_scheduler_if if_c ();
    pipe_scheduler_if if_d ();

    assign if_a.Start = start; assign if_a.Lost = lost; assign if_a.Tick = tick; assign if_a.BirdX = birdx;
    assign if_b.Start = start; assign if_b.Lost = lost; assign if_b.Tick = tick; assign if_b.BirdX = birdx;
    assign if_c.Start = start; assign if_c.Lost = lost; assign if_c.Tick = tick; assign if_c.BirdX = birdx;
    assign if_d.Start = start; assign if_d.Lost = lost; assign if_d.Tick = tick; assign if_d.BirdX = birdx;

    pipe_scheduler #(.SPAWN_X(800), .SPAWN_INTERVAL(4))   u_a (.Clk(Clk), .Reset(Reset), .bus(if_a));
    pipe_scheduler #(.SPAWN_X(800), .SPAWN_INTERVAL(1))   u_b (.Clk(Clk), .Reset(Reset), .bus(if_b));
    pipe_scheduler #(.SPAWN_X(3),   .SPAWN_INTERVAL(100)) u_c (.Clk(Clk), .Reset(Reset), .bus(if_c));
    pipe_scheduler #(.SPAWN_X(1),   .SPAWN_INTERVAL(1))   u_d (.Clk(Clk), .Reset(Reset), .bus(if_d));

    // Reference LFSR: shifts left, new bit = bit8 xor bit4; read only at negedges.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) m_lfsr = 9'h001;
        else       m_lfsr = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
    end

    function automatic logic [9:0] gap_of(input logic [8:0] l);
        if (l < 9'd475) return 10'(l) + 10'd25;
        else            return 10'(l) - 10'd450;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else             n_pass++;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge Clk);
        tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic sync_reset();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    typedef struct {
        logic       start, lost, tick;
        logic       run;
        logic [2:0] va;
        logic [9:0] xa0, xa1;
        logic [2:0] vb;
        logic [9:0] xb0;
        logic       ovb;
    } vec_t;

    vec_t vecs [13];
    logic [9:0] c_x0 [1:6];
    logic       c_v0 [1:6];
    logic       c_sc [1:6];

    initial begin
        // start lost tick | run va xa0 xa1 vb xb0 ovb   (a: interval 4, b: interval 1)
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 10'd0,   10'd0,   3'b000, 10'd0,   1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 10'd800, 10'd0,   3'b001, 10'd800, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 10'd799, 10'd0,   3'b011, 10'd799, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 10'd798, 10'd0,   3'b111, 10'd798, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 10'd797, 10'd0,   3'b111, 10'd797, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 10'd796, 10'd800, 3'b111, 10'd796, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 10'd796, 10'd800, 3'b111, 10'd796, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 10'd796, 10'd800, 3'b111, 10'd796, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 10'd796, 10'd800, 3'b111, 10'd796, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 10'd0,   10'd0,   3'b000, 10'd0,   1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 10'd0,   10'd0,   3'b000, 10'd0,   1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 10'd0,   10'd0,   3'b000, 10'd0,   1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 10'd800, 10'd0,   3'b001, 10'd800, 1'b0};

        // SPAWN_X=3, BirdX=1: X0 after each Tick, valid0, and ScoreInc (X0==1 before the Tick).
        c_x0[1] = 10'd3; c_x0[2] = 10'd2; c_x0[3] = 10'd1; c_x0[4] = 10'd0; c_x0[5] = 10'd0; c_x0[6] = 10'd0;
        c_v0[1] = 1'b1;  c_v0[2] = 1'b1;  c_v0[3] = 1'b1;  c_v0[4] = 1'b1;  c_v0[5] = 1'b0;  c_v0[6] = 1'b0;
        c_sc[1] = 1'b0;  c_sc[2] = 1'b0;  c_sc[3] = 1'b0;  c_sc[4] = 1'b1;  c_sc[5] = 1'b0;  c_sc[6] = 1'b0;

        Reset = 1'b1; start = 1'b0; lost = 1'b0; tick = 1'b0; birdx = 10'd1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_valid_a", 32'(if_a.PipeValid), 32'd0);
        check("rst_x0_a", 32'(if_a.PipeX0), 32'd0);
        check("rst_y0_a", 32'(if_a.PipeY0), 32'd0);
        check("rst_running_b", 32'(if_b.Running), 32'd0);
        check("rst_score_c", 32'(if_c.ScoreInc), 32'd0);
        check("rst_overrun_d", 32'(if_d.SpawnOverrun), 32'd0);

        for (int i = 0; i < 13; i++) begin
            start = vecs[i].start; lost = vecs[i].lost; tick = vecs[i].tick;
            @(negedge Clk);
            check($sformatf("v%0d_running", i), 32'(if_a.Running), 32'(vecs[i].run));
            check($sformatf("v%0d_valid_a", i), 32'(if_a.PipeValid), 32'(vecs[i].va));
            check($sformatf("v%0d_x0_a", i), 32'(if_a.PipeX0), 32'(vecs[i].xa0));
            check($sformatf("v%0d_x1_a", i), 32'(if_a.PipeX1), 32'(vecs[i].xa1));
            check($sformatf("v%0d_valid_b", i), 32'(if_b.PipeValid), 32'(vecs[i].vb));
            check($sformatf("v%0d_x0_b", i), 32'(if_b.PipeX0), 32'(vecs[i].xb0));
            check($sformatf("v%0d_overrun_b", i), 32'(if_b.SpawnOverrun), 32'(vecs[i].ovb));
            if (vecs[i].va[0]) begin
                check($sformatf("v%0d_y0_range_a", i),
                      32'(if_a.PipeY0 >= 10'd25 && if_a.PipeY0 <= 10'd499), 32'd1);
            end else begin
                check($sformatf("v%0d_y0_a", i), 32'(if_a.PipeY0), 32'd0);
            end
        end
        start = 1'b0; lost = 1'b0; tick = 1'b0;

        // Reset arriving between edges while a ScoreInc pulse is showing.
        sync_reset();
        pulse_start();
        for (int t = 1; t <= 4; t++) begin
            pulse_tick();
            if (t < 4) @(negedge Clk);
        end
        check("pre_async_score_c", 32'(if_c.ScoreInc), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("async_score_c", 32'(if_c.ScoreInc), 32'd0);
        check("async_valid_c", 32'(if_c.PipeValid), 32'd0);
        check("async_x0_c", 32'(if_c.PipeX0), 32'd0);
        check("async_valid_a", 32'(if_a.PipeValid), 32'd0);
        check("async_y0_a", 32'(if_a.PipeY0), 32'd0);
        check("async_running_a", 32'(if_a.Running), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int t = 0; t < 2; t++) begin
            pulse_tick();
            check($sformatf("no_start_valid_b_%0d", t), 32'(if_b.PipeValid), 32'd0);
            check($sformatf("no_start_running_b_%0d", t), 32'(if_b.Running), 32'd0);
        end

        // Bird crossing, slot expiry and no reuse on the expiry Tick.
        pulse_start();
        for (int t = 1; t <= 6; t++) begin
            pulse_tick();
            check($sformatf("c_t%0d_x0", t), 32'(if_c.PipeX0), 32'(c_x0[t]));
            check($sformatf("c_t%0d_valid0", t), 32'(if_c.PipeValid[0]), 32'(c_v0[t]));
            check($sformatf("c_t%0d_score", t), 32'(if_c.ScoreInc), 32'(c_sc[t]));
            @(negedge Clk);
            check($sformatf("c_t%0d_score_gap", t), 32'(if_c.ScoreInc), 32'd0);
            check($sformatf("c_t%0d_x0_hold", t), 32'(if_c.PipeX0), 32'(c_x0[t]));
        end

        // Gap scoreboard: one spawn per Tick, each compared against the reference LFSR.
        sync_reset();
        pulse_start();
        tick = 1'b1;
        for (int k = 0; k < 600; k++) begin
            logic [9:0] dx [3];
            logic [9:0] dy [3];
            logic       found;
            exp_q.push_back(gap_of(m_lfsr));
            @(negedge Clk);
            dx[0] = if_d.PipeX0; dx[1] = if_d.PipeX1; dx[2] = if_d.PipeX2;
            dy[0] = if_d.PipeY0; dy[1] = if_d.PipeY1; dy[2] = if_d.PipeY2;
            found = 1'b0;
            for (int s = 0; s < 3; s++) begin
                if (!found && if_d.PipeValid[s] && dx[s] == 10'd1 && exp_q.size() > 0) begin
                    found = 1'b1;
                    check($sformatf("spawn%0d_y", k), 32'(dy[s]), 32'(exp_q.pop_front()));
                end
            end
            if (!found) check($sformatf("spawn%0d_present", k), 32'd0, 32'd1);
        end
        tick = 1'b0;
        @(negedge Clk);
        check("d_overrun", 32'(if_d.SpawnOverrun), 32'd0);
        check("d_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
